// File: rtl/key_input_encoder_pkg.sv
// Shared widths, note/octave codes and helpers for the piano key front-end.
package key_input_encoder_pkg;

  localparam int unsigned N_KEY    = 7;
  localparam int unsigned N_BTN    = 3;
  localparam int unsigned N_PITCH  = 2;
  localparam int unsigned N_RAW    = N_KEY + N_BTN + N_PITCH;
  localparam int unsigned NOTE_W   = 3;
  localparam int unsigned OCT_W    = 2;
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned HIST_LEN = 6;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_NONE = 3'd0,
    NOTE_DO   = 3'd1,
    NOTE_RE   = 3'd2,
    NOTE_MI   = 3'd3,
    NOTE_FA   = 3'd4,
    NOTE_SOL  = 3'd5,
    NOTE_LA   = 3'd6,
    NOTE_SI   = 3'd7
  } note_e;

  typedef enum logic [OCT_W-1:0] {
    OCT_LOW  = 2'd0,
    OCT_MID  = 2'd1,
    OCT_HIGH = 2'd2
  } oct_e;

  // Bits needed to count 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'(1) << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_input_encoder_if.sv
// Raw player inputs and encoded note/button/digit outputs of the key front-end.
interface key_input_encoder_if;
  import key_input_encoder_pkg::*;

  logic [N_KEY-1:0]   key;
  logic [N_BTN-1:0]   button;
  logic [N_PITCH-1:0] pitch;
  logic               note_valid;
  logic [NOTE_W-1:0]  note_idx;
  logic [OCT_W-1:0]   octave;
  logic [N_BTN-1:0]   btn_pulse;
  logic [DIGIT_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7;

  modport master (
    output key, button, pitch,
    input  note_valid, note_idx, octave, btn_pulse, p0, p1, p2, p3, p4, p5, p6, p7
  );

  modport slave (
    input  key, button, pitch,
    output note_valid, note_idx, octave, btn_pulse, p0, p1, p2, p3, p4, p5, p6, p7
  );
endinterface

// File: rtl/key_input_encoder_debounce_sync.sv
// One raw input: 2-FF synchroniser followed by a stable-for-DB_CYCLES debouncer.
module key_input_encoder_debounce_sync
  import key_input_encoder_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int unsigned CNT_W = (clog2(DB_CYCLES) > 0) ? clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Any return to the stable level restarts the count, so short glitches are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/key_input_encoder.sv
// Debounces keys/buttons/pitch switches, priority-encodes the held note and keeps a
// six-deep note history for the seven-segment digits.
module key_input_encoder
  import key_input_encoder_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  key_input_encoder_if.slave bus
);

  logic [N_RAW-1:0]   w_raw;
  logic [N_RAW-1:0]   w_stable;
  logic [N_KEY-1:0]   w_key_st;
  logic [N_BTN-1:0]   w_btn_st;
  logic [N_PITCH-1:0] w_pitch_st;
  logic [NOTE_W-1:0]  w_note;
  logic [OCT_W-1:0]   w_oct;
  logic               w_onset;

  logic               r_note_valid;
  logic [NOTE_W-1:0]  r_note_idx;
  logic [OCT_W-1:0]   r_octave;
  logic [N_BTN-1:0]   r_btn_st_d;
  logic [N_BTN-1:0]   r_btn_pulse;
  logic [NOTE_W-1:0]  r_hist [HIST_LEN];

  assign w_raw = {bus.pitch, bus.button, bus.key};

  for (genvar gi = 0; gi < N_RAW; gi++) begin : g_db
    key_input_encoder_debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (w_raw[gi]),
      .o_stable (w_stable[gi])
    );
  end

  assign w_key_st   = w_stable[N_KEY-1:0];
  assign w_btn_st   = w_stable[N_KEY+N_BTN-1:N_KEY];
  assign w_pitch_st = w_stable[N_RAW-1:N_KEY+N_BTN];

  // Ascending scan so the highest key (do) overrides the lower ones.
  always_comb begin
    w_note = NOTE_NONE;
    for (int i = 0; i < N_KEY; i++) begin
      if (w_key_st[i]) w_note = NOTE_SI - NOTE_W'(i);
    end
  end

  always_comb begin
    w_oct = OCT_MID;
    if (w_pitch_st == 2'b01)      w_oct = OCT_LOW;
    else if (w_pitch_st == 2'b10) w_oct = OCT_HIGH;
  end

  assign w_onset = (w_note != NOTE_NONE) && (w_note != r_note_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note_valid <= 1'b0;
      r_note_idx   <= NOTE_NONE;
      r_octave     <= OCT_LOW;
      r_btn_st_d   <= '0;
      r_btn_pulse  <= '0;
      for (int i = 0; i < HIST_LEN; i++) r_hist[i] <= NOTE_NONE;
    end else begin
      r_note_valid <= |w_key_st;
      r_note_idx   <= w_note;
      r_octave     <= w_oct;
      r_btn_st_d   <= w_btn_st;
      r_btn_pulse  <= w_btn_st & ~r_btn_st_d;
      if (w_onset) begin
        for (int i = HIST_LEN - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
        r_hist[0] <= w_note;
      end
    end
  end

  assign bus.note_valid = r_note_valid;
  assign bus.note_idx   = r_note_idx;
  assign bus.octave     = r_octave;
  assign bus.btn_pulse  = r_btn_pulse;
  assign bus.p0         = DIGIT_W'(r_note_idx);
  assign bus.p1         = DIGIT_W'(r_octave);
  assign bus.p2         = DIGIT_W'(r_hist[0]);
  assign bus.p3         = DIGIT_W'(r_hist[1]);
  assign bus.p4         = DIGIT_W'(r_hist[2]);
  assign bus.p5         = DIGIT_W'(r_hist[3]);
  assign bus.p6         = DIGIT_W'(r_hist[4]);
  assign bus.p7         = DIGIT_W'(r_hist[5]);

endmodule

// File: tb/tb_key_input_encoder.sv
// Scoreboard bench for key_input_encoder with a 4-cycle debounce.
module tb_key_input_encoder;
  import key_input_encoder_pkg::*;

  localparam int unsigned DB = 4;
  localparam int K_NI  = 0;
  localparam int K_NV  = 1;
  localparam int K_OCT = 2;
  localparam int K_BTN = 3;
  localparam int K_P0  = 4;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   hist [HIST_LEN];
  exp_t sb [$];
  exp_t mon_e;

  logic [1:0] pit_tab [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  int         oct_tab [4] = '{0, 2, 1, 1};
  logic [6:0] kv;

  always #5 clk = ~clk;

  key_input_encoder_if bus();

  key_input_encoder #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int k);
    case (k)
      K_NI:     obs = 32'(bus.note_idx);
      K_NV:     obs = 32'(bus.note_valid);
      K_OCT:    obs = 32'(bus.octave);
      K_BTN:    obs = 32'(bus.btn_pulse);
      K_P0:     obs = 32'(bus.p0);
      K_P0 + 1: obs = 32'(bus.p1);
      K_P0 + 2: obs = 32'(bus.p2);
      K_P0 + 3: obs = 32'(bus.p3);
      K_P0 + 4: obs = 32'(bus.p4);
      K_P0 + 5: obs = 32'(bus.p5);
      K_P0 + 6: obs = 32'(bus.p6);
      K_P0 + 7: obs = 32'(bus.p7);
      default:  obs = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Pops every expectation due this cycle and compares it with the live outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc) chk({mon_e.tag, "_late"}, 32'(cyc), 32'(mon_e.cyc));
      else                  chk(mon_e.tag, obs(mon_e.kind), 32'(mon_e.val));
    end
  end

  task automatic expect_at(input int dly, input int kind, input int val, input string tag);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input int dly, input string tag);
    for (int k = 0; k < 12; k++) expect_at(dly, k, 0, $sformatf("%s_k%0d", tag, k));
  endtask

  task automatic expect_note(input int dly, input int n, input string tag);
    expect_at(dly, K_NI, n, {tag, "_ni"});
    expect_at(dly, K_NV, (n != 0) ? 1 : 0, {tag, "_nv"});
    expect_at(dly, K_P0, n, {tag, "_p0"});
  endtask

  task automatic expect_hist(input int dly, input string tag);
    for (int i = 0; i < HIST_LEN; i++)
      expect_at(dly, K_P0 + 2 + i, hist[i], $sformatf("%s_p%0d", tag, i + 2));
  endtask

  task automatic onset(input int n);
    for (int i = HIST_LEN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = n;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() > 0) begin
      chk("sb_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < HIST_LEN; i++) hist[i] = 0;
    rst        = 1'b1;
    bus.key    = '1;
    bus.button = '1;
    bus.pitch  = '1;

    // Reset with every input asserted: outputs stay zero through the first cycle after.
    step(1);
    expect_zero(0, "rst0");
    expect_zero(1, "rst1");
    expect_zero(2, "rst_after");
    step(2);
    rst = 1'b0;
    expect_at(1, K_OCT, 1, "rst_oct00");
    expect_at(1, K_P0 + 1, 1, "rst_p1");
    step(1);
    bus.key    = '0;
    bus.button = '0;
    bus.pitch  = '0;
    expect_note(6, 0, "rst_glitch");
    expect_at(6, K_BTN, 0, "rst_glitch_btn");
    expect_hist(6, "rst_glitch");
    drain();
    step(4);

    // Single key: re (note 2) appears exactly 7 cycles after the raw edge.
    bus.key = 7'b0100000;
    expect_at(6, K_NV, 0, "re_early_nv");
    expect_note(7, 2, "re");
    onset(2);
    expect_hist(7, "re");
    drain();
    bus.key = '0;
    expect_note(7, 0, "re_rel");
    expect_hist(7, "re_rel");
    drain();

    // Glitch one cycle shorter than the debounce window.
    bus.key = 7'b0010000;
    expect_note(7, 0, "glitch_a");
    expect_note(9, 0, "glitch_b");
    expect_hist(9, "glitch");
    step(3);
    bus.key = '0;
    drain();

    // Priority: la+si held, then do added and released again.
    bus.key = 7'b0000011;
    expect_note(7, 6, "lasi");
    onset(6);
    expect_hist(7, "lasi");
    drain();
    bus.key = 7'b1000011;
    expect_note(7, 1, "do_over");
    onset(1);
    expect_hist(7, "do_over");
    drain();
    bus.key = 7'b0000011;
    expect_note(7, 6, "back_la");
    onset(6);
    expect_hist(7, "back_la");
    drain();
    bus.key = '0;
    expect_note(7, 0, "all_rel");
    expect_hist(7, "all_rel");
    drain();

    // Buttons prev+next held: one pulse on press, none on release.
    bus.button = 3'b101;
    expect_at(6, K_BTN, 0, "btn_pre");
    expect_at(7, K_BTN, 5, "btn_pulse");
    expect_at(8, K_BTN, 0, "btn_once");
    expect_at(15, K_BTN, 0, "btn_held");
    drain();
    step(4);
    bus.button = '0;
    expect_at(6, K_BTN, 0, "btn_rel6");
    expect_at(7, K_BTN, 0, "btn_rel7");
    expect_at(8, K_BTN, 0, "btn_rel8");
    drain();

    // Octave mapping; an octave change alone never touches the history.
    for (int i = 0; i < 4; i++) begin
      bus.pitch = pit_tab[i];
      expect_at(7, K_OCT, oct_tab[i], $sformatf("oct%0d", i));
      expect_at(7, K_P0 + 1, oct_tab[i], $sformatf("oct%0d_p1", i));
      expect_note(7, 0, $sformatf("oct%0d", i));
      expect_hist(7, $sformatf("oct%0d", i));
      drain();
    end

    // Seven distinct onsets push the oldest entries out of p7.
    for (int k = 0; k < 7; k++) begin
      kv = 7'b1000000;
      bus.key = kv >> k;
      expect_note(7, k + 1, $sformatf("seq%0d", k));
      onset(k + 1);
      expect_hist(7, $sformatf("seq%0d", k));
      drain();
    end
    bus.key = '0;
    expect_note(7, 0, "seq_rel");
    expect_hist(7, "seq_rel");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
